// File: rtl/id_ex_alu_ctrl.sv
// ID/EX pipeline register with ALU slice-control decode, stall hold and flush bubble.
// Optional IDEX_PERF_CNT_EN adds stall_cnt / flush_cnt performance counters.
module id_ex_alu_ctrl #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [1:0]        id_alu_op,
   input  logic [5:0]        id_funct,
   input  logic              id_alu_src,
   input  logic              id_reg_dst,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_mem_to_reg,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [REG_AW-1:0] ex_dst,
   output logic [2:0]        ex_sel,
   output logic              ex_inv,
   output logic              ex_cin,
   output logic              ex_slt,
   output logic              ex_illegal,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_mem_to_reg
`ifdef IDEX_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
`endif
);

   localparam logic [2:0] SEL_AND = 3'b000;
   localparam logic [2:0] SEL_OR  = 3'b001;
   localparam logic [2:0] SEL_ADD = 3'b010;
   localparam logic [2:0] SEL_SUB = 3'b110;

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [DATA_W-1:0] rt_data;
      logic [REG_AW-1:0] dst;
      logic [2:0]        sel;
      logic              inv;
      logic              slt;
      logic              illegal;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              mem_to_reg;
   } ex_t;

   ex_t q;
   ex_t d;

   logic [2:0] dec_sel;
   logic       dec_inv;
   logic       dec_slt;
   logic       dec_ill;

   always_comb begin
      dec_sel = SEL_ADD;
      dec_inv = 1'b0;
      dec_slt = 1'b0;
      dec_ill = 1'b0;
      unique case (id_alu_op)
         2'b00: dec_sel = SEL_ADD;
         2'b01: begin
            dec_sel = SEL_SUB;
            dec_inv = 1'b1;
         end
         2'b10: begin
            unique case (id_funct)
               6'h20: dec_sel = SEL_ADD;
               6'h22: begin
                  dec_sel = SEL_SUB;
                  dec_inv = 1'b1;
               end
               6'h24: dec_sel = SEL_AND;
               6'h25: dec_sel = SEL_OR;
               6'h2a: begin
                  dec_sel = SEL_SUB;
                  dec_inv = 1'b1;
                  dec_slt = 1'b1;
               end
               default: dec_ill = 1'b1;
            endcase
         end
         default: dec_ill = 1'b1;
      endcase
   end

   // an undecodable op still occupies EX but must not touch state
   always_comb begin
      d            = '0;
      d.valid      = 1'b1;
      d.a          = id_rs_data;
      d.b          = id_alu_src ? id_imm : id_rt_data;
      d.rt_data    = id_rt_data;
      d.dst        = id_reg_dst ? id_rd : id_rt;
      d.sel        = dec_sel;
      d.inv        = dec_inv;
      d.slt        = dec_slt;
      d.illegal    = dec_ill;
      d.reg_write  = id_reg_write & ~dec_ill;
      d.mem_read   = id_mem_read & ~dec_ill;
      d.mem_write  = id_mem_write & ~dec_ill;
      d.mem_to_reg = id_mem_to_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (flush) begin
         q <= '0;
      end else if (!stall) begin
         q <= id_valid ? d : '0;
      end
   end

   assign ex_valid      = q.valid;
   assign ex_a          = q.a;
   assign ex_b          = q.b;
   assign ex_rt_data    = q.rt_data;
   assign ex_dst        = q.dst;
   assign ex_sel        = q.sel;
   assign ex_inv        = q.inv;
   assign ex_cin        = q.inv;
   assign ex_slt        = q.slt;
   assign ex_illegal    = q.illegal;
   assign ex_reg_write  = q.reg_write;
   assign ex_mem_read   = q.mem_read;
   assign ex_mem_write  = q.mem_write;
   assign ex_mem_to_reg = q.mem_to_reg;

`ifdef IDEX_PERF_CNT_EN
   logic stall_hit;
   logic flush_hit;

   assign stall_hit = stall & ~flush;
   assign flush_hit = flush | (~stall & ~id_valid);

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_hit) stall_cnt <= stall_cnt + 32'd1;
         if (flush_hit) flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_alu_ctrl.sv
// Bench for id_ex_alu_ctrl: instruction-level model of the EX slot plus
// directed vectors with literal expectations.
module tb_id_ex_alu_ctrl;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst, stall, flush, id_valid;
   logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
   logic [AW-1:0] id_rt, id_rd;
   logic [1:0]    id_alu_op;
   logic [5:0]    id_funct;
   logic          id_alu_src, id_reg_dst;
   logic          id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
   logic          ex_valid;
   logic [DW-1:0] ex_a, ex_b, ex_rt_data;
   logic [AW-1:0] ex_dst;
   logic [2:0]    ex_sel;
   logic          ex_inv, ex_cin, ex_slt, ex_illegal;
   logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
`ifdef IDEX_PERF_CNT_EN
   logic [31:0]   stall_cnt, flush_cnt;
   logic [31:0]   m_sc, m_fc;
   bit            cnt_chk = 1'b0;
`endif

   always #5 clk = ~clk;

   id_ex_alu_ctrl #(.DATA_W(DW), .REG_AW(AW)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_rs_data(id_rs_data),
      .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_rt(id_rt), .id_rd(id_rd),
      .id_alu_op(id_alu_op), .id_funct(id_funct),
      .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
      .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
      .ex_rt_data(ex_rt_data), .ex_dst(ex_dst),
      .ex_sel(ex_sel), .ex_inv(ex_inv), .ex_cin(ex_cin),
      .ex_slt(ex_slt), .ex_illegal(ex_illegal),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
`ifdef IDEX_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   int vectors     = 0;
   int miscompares = 0;
   bit check_en    = 1'b0;

   typedef struct packed {
      logic          valid;
      logic [DW-1:0] a, b, rtd;
      logic [AW-1:0] dst;
      logic [2:0]    sel;
      logic          inv, slt, ill, rw, mr, mw, m2r;
   } slot_t;

   slot_t m;

   // What the instruction now sitting in ID must look like once it reaches EX
   function automatic slot_t capture();
      slot_t s;
      s       = '0;
      s.valid = 1'b1;
      s.a     = id_rs_data;
      s.b     = id_alu_src ? id_imm : id_rt_data;
      s.rtd   = id_rt_data;
      s.dst   = id_reg_dst ? id_rd : id_rt;
      s.rw    = id_reg_write;
      s.mr    = id_mem_read;
      s.mw    = id_mem_write;
      s.m2r   = id_mem_to_reg;
      if (id_alu_op == 2'b00 || (id_alu_op == 2'b10 && id_funct == 6'h20)) begin
         s.sel = 3'b010;
      end else if (id_alu_op == 2'b01 || (id_alu_op == 2'b10 && id_funct == 6'h22)) begin
         s.sel = 3'b110; s.inv = 1'b1;
      end else if (id_alu_op == 2'b10 && id_funct == 6'h24) begin
         s.sel = 3'b000;
      end else if (id_alu_op == 2'b10 && id_funct == 6'h25) begin
         s.sel = 3'b001;
      end else if (id_alu_op == 2'b10 && id_funct == 6'h2a) begin
         s.sel = 3'b110; s.inv = 1'b1; s.slt = 1'b1;
      end else begin
         s.sel = 3'b010; s.ill = 1'b1;
         s.rw  = 1'b0; s.mr = 1'b0; s.mw = 1'b0;
      end
      return s;
   endfunction

   always @(posedge clk) begin
      if (rst)                    m <= '0;
      else if (flush)             m <= '0;
      else if (stall)             m <= m;
      else if (!id_valid)         m <= '0;
      else                        m <= capture();
   end

`ifdef IDEX_PERF_CNT_EN
   always @(posedge clk) begin
      if (rst) begin
         m_sc <= '0;
         m_fc <= '0;
      end else begin
         if (stall && !flush)                  m_sc <= m_sc + 32'd1;
         if (flush || (!stall && !id_valid))   m_fc <= m_fc + 32'd1;
      end
   end
`endif

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         chk("valid", ex_valid, m.valid);
         chk("a", ex_a, m.a);
         chk("b", ex_b, m.b);
         chk("rt_data", ex_rt_data, m.rtd);
         chk("dst", ex_dst, m.dst);
         chk("sel", ex_sel, m.sel);
         chk("inv", ex_inv, m.inv);
         chk("cin", ex_cin, m.inv);
         chk("slt", ex_slt, m.slt);
         chk("illegal", ex_illegal, m.ill);
         chk("reg_write", ex_reg_write, m.rw);
         chk("mem_read", ex_mem_read, m.mr);
         chk("mem_write", ex_mem_write, m.mw);
         chk("mem_to_reg", ex_mem_to_reg, m.m2r);
         chk("sel_legal", ex_sel inside {3'b000, 3'b001, 3'b010, 3'b110}, 1'b1);
`ifdef IDEX_PERF_CNT_EN
         if (cnt_chk) begin
            chk("stall_cnt", stall_cnt, m_sc);
            chk("flush_cnt", flush_cnt, m_fc);
         end
`endif
      end
   end

   task automatic rand_data();
      id_rs_data = $urandom;
      id_rt_data = $urandom;
      id_imm     = $urandom;
      id_rt      = AW'($urandom_range(0, 31));
      id_rd      = AW'($urandom_range(0, 31));
   endtask

   task automatic instr(input logic [1:0] op, input logic [5:0] fn,
                        input bit src, input bit rdst, input bit rw,
                        input bit mr, input bit mw, input bit m2r);
      rand_data();
      id_valid      = 1'b1;
      id_alu_op     = op;
      id_funct      = fn;
      id_alu_src    = src;
      id_reg_dst    = rdst;
      id_reg_write  = rw;
      id_mem_read   = mr;
      id_mem_write  = mw;
      id_mem_to_reg = m2r;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   logic [5:0] fn_tab [5];
   logic [4:0] exp_tab [5];

   initial begin
      fn_tab  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
      // {sel, inv, slt}
      exp_tab = '{5'b010_0_0, 5'b110_1_0, 5'b000_0_0, 5'b001_0_0, 5'b110_1_1};

      rst = 1'b1; stall = 1'(($urandom)); flush = 1'(($urandom));
      instr(2'($urandom), 6'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
      check_en = 1'b1;
      instr(2'($urandom), 6'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
      rst = 1'b0; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
      tick();
      chk("rst_valid", ex_valid, 1'b0);
      chk("rst_sel", ex_sel, 3'b000);
      chk("rst_a", ex_a, 32'h0);
      chk("rst_rw", ex_reg_write, 1'b0);

      for (int i = 0; i < 5; i++) begin
         instr(2'b10, fn_tab[i], 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
         tick();
         chk($sformatf("rtype_%0h", fn_tab[i]), {ex_sel, ex_inv, ex_slt}, exp_tab[i]);
         chk("rtype_cin", ex_cin, exp_tab[i][1]);
      end

      instr(2'b00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      id_imm = 32'h0000_0010; id_rt_data = 32'hDEAD_BEEF;
      tick();
      chk("lw_b", ex_b, 32'h0000_0010);
      chk("lw_sel", ex_sel, 3'b010);
      chk("lw_store_data", ex_rt_data, 32'hDEAD_BEEF);
      instr(2'b01, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("beq_sel_inv", {ex_sel, ex_inv}, 4'b110_1);

      instr(2'b10, 6'h25, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      id_rs_data = 32'h1234_5678;
      tick();
      for (int i = 0; i < 3; i++) begin
         stall = 1'b1;
         instr(2'b10, 6'h20, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
         tick();
         chk("stall_hold_a", ex_a, 32'h1234_5678);
         chk("stall_hold_sel", ex_sel, 3'b001);
      end
      flush = 1'b1;
      tick();
      chk("flush_valid", ex_valid, 1'b0);
      chk("flush_ctl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 4'b0);
      stall = 1'b0; flush = 1'b0;

      instr(2'b10, 6'h27, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      chk("ill_flag", ex_illegal, 1'b1);
      chk("ill_valid", ex_valid, 1'b1);
      chk("ill_rw", ex_reg_write, 1'b0);
      chk("ill_sel", ex_sel, 3'b010);
      instr(2'b10, 6'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk("ill_pulse_end", ex_illegal, 1'b0);

      instr(2'b11, 6'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk("op11_ill", ex_illegal, 1'b1);
      stall = 1'b1;
      instr(2'b00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk("ill_held_in_stall", ex_illegal, 1'b1);
      rst = 1'b1;
      tick();
      chk("rst_in_stall", ex_valid, 1'b0);
      rst = 1'b0; stall = 1'b0;

      for (int i = 0; i < 40; i++) begin
         instr(2'($urandom), fn_tab[$urandom_range(0, 4)] ^ (($urandom_range(0, 5) == 0) ? 6'h01 : 6'h00),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom));
         id_valid = ($urandom_range(0, 4) != 0);
         stall    = ($urandom_range(0, 3) == 0);
         flush    = ($urandom_range(0, 5) == 0);
         tick();
      end
      stall = 1'b0; flush = 1'b0;

`ifdef IDEX_PERF_CNT_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cnt_chk = 1'b1;
      instr(2'b00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      flush = 1'b1;
      tick();
      tick();
      flush = 1'b0;
      tick();
      chk("flush_cnt_2", flush_cnt, 32'd2);
      cnt_chk = 1'b0;
      force dut.stall_cnt = 32'hFFFF_FFFF;
      #1 release dut.stall_cnt;
      stall = 1'b1;
      tick();
      stall = 1'b0;
      chk("stall_cnt_wrap", stall_cnt, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
